// File: rtl/tensor_stream_serializer.sv
// Captures a full HxWxC tensor on a valid pulse and drains it one element per
// beat over a valid/ready stream, channel-fastest, with first/last markers.
module tensor_stream_serializer #(
    parameter int unsigned CHANNELS   = 1,
    parameter int unsigned HEIGHT     = 112,
    parameter int unsigned WIDTH      = 112,
    parameter int unsigned DATA_WIDTH = 8,
    localparam int unsigned HW = (HEIGHT   > 1) ? $clog2(HEIGHT)   : 1,
    localparam int unsigned WW = (WIDTH    > 1) ? $clog2(WIDTH)    : 1,
    localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] data_in [0:HEIGHT-1][0:WIDTH-1][0:CHANNELS-1],
    input  logic                         valid_in,
    output logic                         busy,
    output logic signed [DATA_WIDTH-1:0] m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         m_first,
    output logic                         m_last,
    output logic [HW-1:0]                m_h,
    output logic [WW-1:0]                m_w,
    output logic [CW-1:0]                m_c,
    output logic                         overrun
);

    localparam logic [HW-1:0] H_MAX = HW'(HEIGHT - 1);
    localparam logic [WW-1:0] W_MAX = WW'(WIDTH - 1);
    localparam logic [CW-1:0] C_MAX = CW'(CHANNELS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   capture;
    logic   overrun_nxt;
    logic   xfer;
    logic   at_last;

    logic signed [DATA_WIDTH-1:0] frame_buf [0:HEIGHT-1][0:WIDTH-1][0:CHANNELS-1];

    assign at_last = (m_h == H_MAX) && (m_w == W_MAX) && (m_c == C_MAX);
    assign xfer    = (state == STREAM) && m_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, capture strobe and overrun detection
    always_comb begin
        state_nxt   = state;
        capture     = 1'b0;
        overrun_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    capture   = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (xfer && at_last) begin
                    if (valid_in) begin
                        capture = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (valid_in) begin
                    overrun_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Element counters: channel fastest, then column, then row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_h <= '0;
            m_w <= '0;
            m_c <= '0;
        end else if (capture) begin
            m_h <= '0;
            m_w <= '0;
            m_c <= '0;
        end else if (xfer) begin
            if (m_c == C_MAX) begin
                m_c <= '0;
                if (m_w == W_MAX) begin
                    m_w <= '0;
                    m_h <= (m_h == H_MAX) ? '0 : m_h + HW'(1);
                end else begin
                    m_w <= m_w + WW'(1);
                end
            end else begin
                m_c <= m_c + CW'(1);
            end
        end
    end

    // Frame buffer, written only on an accepted capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int h = 0; h < int'(HEIGHT); h++)
                for (int w = 0; w < int'(WIDTH); w++)
                    for (int c = 0; c < int'(CHANNELS); c++)
                        frame_buf[h][w][c] <= '0;
        end else if (capture) begin
            for (int h = 0; h < int'(HEIGHT); h++)
                for (int w = 0; w < int'(WIDTH); w++)
                    for (int c = 0; c < int'(CHANNELS); c++)
                        frame_buf[h][w][c] <= data_in[h][w][c];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else begin
            overrun <= overrun_nxt;
        end
    end

    assign busy    = (state == STREAM);
    assign m_valid = (state == STREAM);
    assign m_first = (state == STREAM) && (m_h == '0) && (m_w == '0) && (m_c == '0);
    assign m_last  = (state == STREAM) && at_last;
    assign m_data  = (state == STREAM) ? frame_buf[m_h][m_w][m_c] : '0;

endmodule

// File: doc/tensor_stream_serializer.md
# tensor_stream_serializer

Reads the full parallel output tensor of a pointwise convolution stage on its `valid_out` pulse and streams it out one element per beat over a valid/ready interface. This lets downstream stream-based logic, such as DMA, write-back or a channel-serial stage, drain a layer without a wide parallel bus. It is the consumer end of the stage's tensor + single-cycle-valid interface.

## Interface
Parameters:
- `CHANNELS`, 1: channels per pixel (third tensor dimension).
- `HEIGHT`, 112: tensor rows.
- `WIDTH`, 112: tensor columns.
- `DATA_WIDTH`, 8: signed element width.
- Index widths: `HW = max(1,$clog2(HEIGHT))`, `WW = max(1,$clog2(WIDTH))`, `CW = max(1,$clog2(CHANNELS))`.

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `data_in`  in  signed [DATA_WIDTH-1:0] [0:HEIGHT-1][0:WIDTH-1][0:CHANNELS-1]  tensor from the upstream stage.
- `valid_in`  in  1  single-cycle pulse: `data_in` is valid this cycle.
- `busy`  out  1  frame held and not fully drained.
- `m_data`  out  signed [DATA_WIDTH-1:0]  current element.
- `m_valid`  out  1  `m_data` and index outputs are valid.
- `m_ready`  in  1  downstream accepts the beat.
- `m_first`  out  1  beat is element [0][0][0].
- `m_last`  out  1  beat is element [HEIGHT-1][WIDTH-1][CHANNELS-1].
- `m_h`, `m_w`, `m_c`  out  HW/WW/CW  indices of the current element.
- `overrun`  out  1  one-cycle pulse: a `valid_in` was dropped.

## Operation
- Two states: IDLE and STREAM. The frame buffer is a full HEIGHT×WIDTH×CHANNELS register copy, loaded only on an accepted capture.
- IDLE: `valid_in`=1 captures the whole of `data_in`, zeroes counters h/w/c and moves to STREAM.
- STREAM: `m_valid`=1 and `m_data`=buf[h][w][c].
- A beat transfers when `m_valid && m_ready`.
- Each transfer advances the counters in order c first, then w, then h:
  - c increments, wrapping to 0 at CHANNELS-1, then w increments.
  - w wraps to 0 at WIDTH-1, then h increments.
- Flags are combinational from the counters:
  - `m_first` = (h==0 && w==0 && c==0).
  - `m_last` = (h==HEIGHT-1 && w==WIDTH-1 && c==CHANNELS-1).
- Transfer with `m_last`=1 ends the frame:
  - With no `valid_in` that cycle: next state IDLE.
  - With `valid_in`=1 in the same cycle: the new frame is captured, counters reset to 0 and the block stays in STREAM. There is no bubble.
- `valid_in` in STREAM, other than on the final transfer cycle: the input is dropped, the buffer and counters are unchanged, and `overrun` pulses high for exactly the next cycle.
- Stall (`m_ready`=0): `m_data`, indices, `m_first` and `m_last` are held stable. `m_valid` is never withdrawn before transfer.
- `busy` = (state==STREAM). `busy` is 1 and `m_valid` is 1 in exactly the same cycles.
- No arithmetic on data: elements pass bit-exact, sign preserved.
- Degenerate HEIGHT=WIDTH=CHANNELS=1: a single beat with `m_first`=`m_last`=1.

## Timing
- Reset values: `m_valid`=0, `busy`=0, `overrun`=0, `m_data`=0, `m_h`/`m_w`/`m_c`=0, `m_first`=0, `m_last`=0. State is IDLE and the buffer is cleared to 0.
- Latency: `valid_in` at cycle N (IDLE) gives `m_valid`=1 with element [0][0][0] at cycle N+1.
- Throughput: one element per cycle with `m_ready` held high.
  - Frame drain takes HEIGHT·WIDTH·CHANNELS cycles.
  - Minimum accepted `valid_in` spacing is also HEIGHT·WIDTH·CHANNELS cycles (back-to-back via the final-transfer rule).
- Final transfer at cycle M with no new capture: `m_valid`=0 and `busy`=0 from M+1.
- `rst` asserted mid-stream aborts immediately: outputs take their reset values asynchronously. No `m_last` is emitted and the partial frame is discarded.
- Outputs are registered or derived only from registered state. There is no combinational path from `m_ready` or `valid_in` to any output.

## Test plan
- Setup: HEIGHT=WIDTH=CHANNELS=2, tensor element value = 16·h+4·w+c. Pulse `valid_in` with `m_ready`=1 -> 8 beats on consecutive cycles: 0,1,4,5,16,17,20,21. `m_first` on beat 0 only, `m_last` on beat 7 only, `busy` low the cycle after beat 7.
- Backpressure: `m_ready` random 50% -> same 8-value sequence, no drops or duplicates, outputs stable across every stall cycle.
- Overrun: second `valid_in` with all elements = -1 at beat 3 -> `overrun`=1 for one cycle, streamed values unchanged (still 16·h+4·w+c), frame ends normally.
- Back-to-back: new `valid_in` (all elements = 7) on the cycle of the `m_last` transfer -> `m_valid` stays high, next beat is 7 with `m_first`=1, no `overrun`.
- Reset mid-stream: assert `rst` after beat 4 -> `m_valid`/`busy` drop to 0 immediately, no `m_last`. After release, a new `valid_in` streams from [0][0][0].
- Degenerate 1×1×1 with `data_in`=-128 -> one beat with `m_data`=-128, `m_first`=`m_last`=1, `busy` for exactly one cycle with `m_ready`=1.
